// File: rtl/dispatch_steer.sv
// dispatch_steer
// Dispatch-stage controller between rename and the dispatch queues. Each cycle
// it accepts the longest in-order prefix of the renamed group that fits the
// per-queue credits. Serializing instructions go through a drain/issue/commit
// sequence. The oldest accepted frontend exception is reported one cycle later.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   i_squash_vld        pipeline flush (restores credits, aborts serialization)
//   i_enq_*             per-lane valid / target queue / serialize / exception /
//                       code / ROB index
//   i_rob_rdy, i_imm_rdy     downstream can take the whole group
//   i_rob_empty         ROB has nothing uncommitted
//   i_commit_serialize  serializing instruction committed
//   i_dq_deq_cnt        entries freed per queue this cycle
//   o_acc_cnt           accepted prefix length (combinational)
//   o_stall             lane 0 valid but nothing accepted
//   o_dq_enq_mask       per-queue lane write enables, index q*WIDTH+lane
//   o_ser_busy          serialization sequence in progress
//   o_exceptwb_*        registered exception writeback
//   o_stall_cnt         {rob, imm, credit, serialize} stall counters
//
// Optional feature: define DISPATCH_STALL_STATS_EN to build the stall counters;
// otherwise o_stall_cnt is tied to zero.
module dispatch_steer #(
  parameter int WIDTH    = 4,
  parameter int NUM_DQ   = 3,
  parameter int DQ_DEPTH = 16,
  parameter int ROBIDX_W = 7,
  localparam int DQID_W  = $clog2(NUM_DQ + 1),
  localparam int CNT_W   = $clog2(DQ_DEPTH + 1),
  localparam int LCNT_W  = $clog2(WIDTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_squash_vld,
  input  logic [WIDTH-1:0]           i_enq_vld,
  input  logic [WIDTH*DQID_W-1:0]    i_enq_dqid,
  input  logic [WIDTH-1:0]           i_enq_serialize,
  input  logic [WIDTH-1:0]           i_enq_except,
  input  logic [WIDTH*5-1:0]         i_enq_except_code,
  input  logic [WIDTH*ROBIDX_W-1:0]  i_enq_robidx,
  input  logic                       i_rob_rdy,
  input  logic                       i_imm_rdy,
  input  logic                       i_rob_empty,
  input  logic                       i_commit_serialize,
  input  logic [NUM_DQ*CNT_W-1:0]    i_dq_deq_cnt,
  output logic [LCNT_W-1:0]          o_acc_cnt,
  output logic                       o_stall,
  output logic [NUM_DQ*WIDTH-1:0]    o_dq_enq_mask,
  output logic                       o_ser_busy,
  output logic                       o_exceptwb_vld,
  output logic [ROBIDX_W-1:0]        o_exceptwb_robidx,
  output logic [4:0]                 o_exceptwb_code,
  output logic [4*32-1:0]            o_stall_cnt
);

  typedef enum logic [1:0] {S_NORM, S_DRAIN, S_SER, S_WAIT} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    credit     [NUM_DQ];
  logic [CNT_W:0]      credit_nxt [NUM_DQ];
  logic [CNT_W-1:0]    dq_deq     [NUM_DQ];
  logic [LCNT_W-1:0]   used       [NUM_DQ];
  logic [LCNT_W-1:0]   enq_cnt    [NUM_DQ];
  logic [DQID_W-1:0]   lane_dqid  [WIDTH];
  logic [ROBIDX_W-1:0] lane_robidx[WIDTH];
  logic [4:0]          lane_code  [WIDTH];
  logic [LCNT_W-1:0]   cand_k, acc_k, ser_idx;
  logic                fits, ser_found, gated;
  logic                exc_found;
  logic [ROBIDX_W-1:0] exc_robidx_nxt;
  logic [4:0]          exc_code_nxt;

  always_comb begin
    for (int l = 0; l < WIDTH; l++) begin
      lane_dqid[l]   = i_enq_dqid[l*DQID_W +: DQID_W];
      lane_robidx[l] = i_enq_robidx[l*ROBIDX_W +: ROBIDX_W];
      lane_code[l]   = i_enq_except_code[l*5 +: 5];
    end
    for (int q = 0; q < NUM_DQ; q++) dq_deq[q] = i_dq_deq_cnt[q*CNT_W +: CNT_W];
  end

  // Walk the lanes in order, consuming credit per target queue; the prefix
  // ends at the first invalid lane or the first lane whose queue is out of
  // credit. Lanes with dqid >= NUM_DQ match no queue and never consume credit.
  always_comb begin
    cand_k = '0;
    fits   = 1'b1;
    for (int q = 0; q < NUM_DQ; q++) used[q] = '0;
    for (int l = 0; l < WIDTH; l++) begin
      if (!i_enq_vld[l]) fits = 1'b0;
      if (fits) begin
        for (int q = 0; q < NUM_DQ; q++) begin
          if (int'(lane_dqid[l]) == q) begin
            if (int'(used[q]) >= int'(credit[q])) fits = 1'b0;
            else used[q] = used[q] + 1'b1;
          end
        end
        if (fits) cand_k = LCNT_W'(l + 1);
      end
    end
  end

  always_comb begin
    ser_found = 1'b0;
    ser_idx   = '0;
    for (int l = 0; l < WIDTH; l++) begin
      if (!ser_found && i_enq_vld[l] && i_enq_serialize[l]) begin
        ser_found = 1'b1;
        ser_idx   = LCNT_W'(l);
      end
    end
  end

  assign gated = i_squash_vld || !i_rob_rdy || !i_imm_rdy;

  // Serialization FSM: a serializing lane waits in lane 0 until the ROB
  // drains, is dispatched alone, then nothing else enters until it commits.
  always_comb begin
    state_nxt = state;
    acc_k     = cand_k;
    unique case (state)
      S_NORM: begin
        if (ser_found) begin
          if (ser_idx == '0) begin
            acc_k     = '0;
            state_nxt = S_DRAIN;
          end else if (cand_k > ser_idx) begin
            acc_k = ser_idx;
          end
        end
      end
      S_DRAIN: begin
        acc_k = '0;
        if (i_rob_empty) state_nxt = S_SER;
      end
      S_SER: begin
        if (cand_k > LCNT_W'(1)) acc_k = LCNT_W'(1);
        if (!gated && acc_k != '0) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        acc_k = '0;
        if (i_commit_serialize) state_nxt = S_NORM;
      end
      default: state_nxt = S_NORM;
    endcase
    if (gated) acc_k = '0;
    if (i_squash_vld) state_nxt = S_NORM;
  end

  always_comb begin
    o_dq_enq_mask  = '0;
    exc_found      = 1'b0;
    exc_robidx_nxt = '0;
    exc_code_nxt   = '0;
    for (int q = 0; q < NUM_DQ; q++) enq_cnt[q] = '0;
    for (int l = 0; l < WIDTH; l++) begin
      if (LCNT_W'(l) < acc_k) begin
        for (int q = 0; q < NUM_DQ; q++) begin
          if (int'(lane_dqid[l]) == q) begin
            o_dq_enq_mask[q*WIDTH + l] = 1'b1;
            enq_cnt[q]                 = enq_cnt[q] + 1'b1;
          end
        end
        if (!exc_found && i_enq_except[l]) begin
          exc_found      = 1'b1;
          exc_robidx_nxt = lane_robidx[l];
          exc_code_nxt   = lane_code[l];
        end
      end
    end
    for (int q = 0; q < NUM_DQ; q++)
      credit_nxt[q] = {1'b0, credit[q]} + {1'b0, dq_deq[q]} - (CNT_W+1)'(enq_cnt[q]);
  end

  assign o_acc_cnt  = acc_k;
  assign o_stall    = i_enq_vld[0] && (acc_k == '0);
  assign o_ser_busy = (state != S_NORM);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= S_NORM;
      o_exceptwb_vld    <= 1'b0;
      o_exceptwb_robidx <= '0;
      o_exceptwb_code   <= '0;
      for (int q = 0; q < NUM_DQ; q++) credit[q] <= CNT_W'(DQ_DEPTH);
    end else begin
      state          <= state_nxt;
      o_exceptwb_vld <= exc_found && !i_squash_vld;
      if (exc_found) begin
        o_exceptwb_robidx <= exc_robidx_nxt;
        o_exceptwb_code   <= exc_code_nxt;
      end
      for (int q = 0; q < NUM_DQ; q++)
        credit[q] <= i_squash_vld ? CNT_W'(DQ_DEPTH) : credit_nxt[q][CNT_W-1:0];
    end
  end

  // Returned plus remaining credit can never exceed the queue depth.
  always_ff @(posedge clk) begin
    if (rst && !i_squash_vld) begin
      for (int q = 0; q < NUM_DQ; q++)
        assert (credit_nxt[q] <= (CNT_W+1)'(DQ_DEPTH));
    end
  end

`ifdef DISPATCH_STALL_STATS_EN
  // Counter index: 3 rob, 2 imm, 1 credit, 0 serialize.
  logic [31:0] stall_cnt [4];
  logic [1:0]  stall_reason;

  always_comb begin
    if (!i_rob_rdy)                                            stall_reason = 2'd3;
    else if (!i_imm_rdy)                                       stall_reason = 2'd2;
    else if (state != S_NORM || (ser_found && ser_idx == '0))  stall_reason = 2'd0;
    else                                                       stall_reason = 2'd1;
  end

  // Saturating; squash deliberately leaves the statistics alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) stall_cnt[i] <= '0;
    end else if (o_stall && stall_cnt[stall_reason] != '1) begin
      stall_cnt[stall_reason] <= stall_cnt[stall_reason] + 32'd1;
    end
  end

  assign o_stall_cnt = {stall_cnt[3], stall_cnt[2], stall_cnt[1], stall_cnt[0]};
`else
  assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dispatch_steer.sv
// Testbench for dispatch_steer: directed scenarios plus randomized traffic,
// checked against a behavioural model through an expectation queue.
module tb_dispatch_steer;

  localparam int WIDTH    = 4;
  localparam int NUM_DQ   = 3;
  localparam int DQ_DEPTH = 16;
  localparam int ROBIDX_W = 7;
  localparam int DQID_W   = 2;
  localparam int CNT_W    = 5;
  localparam int LCNT_W   = 3;

  logic                      clk;
  logic                      rst;
  logic                      i_squash_vld;
  logic [WIDTH-1:0]          i_enq_vld;
  logic [WIDTH*DQID_W-1:0]   i_enq_dqid;
  logic [WIDTH-1:0]          i_enq_serialize;
  logic [WIDTH-1:0]          i_enq_except;
  logic [WIDTH*5-1:0]        i_enq_except_code;
  logic [WIDTH*ROBIDX_W-1:0] i_enq_robidx;
  logic                      i_rob_rdy, i_imm_rdy, i_rob_empty, i_commit_serialize;
  logic [NUM_DQ*CNT_W-1:0]   i_dq_deq_cnt;
  logic [LCNT_W-1:0]         o_acc_cnt;
  logic                      o_stall;
  logic [NUM_DQ*WIDTH-1:0]   o_dq_enq_mask;
  logic                      o_ser_busy;
  logic                      o_exceptwb_vld;
  logic [ROBIDX_W-1:0]       o_exceptwb_robidx;
  logic [4:0]                o_exceptwb_code;
  logic [127:0]              o_stall_cnt;

  dispatch_steer #(.WIDTH(WIDTH), .NUM_DQ(NUM_DQ), .DQ_DEPTH(DQ_DEPTH), .ROBIDX_W(ROBIDX_W)) dut (
    .clk(clk), .rst(rst), .i_squash_vld(i_squash_vld),
    .i_enq_vld(i_enq_vld), .i_enq_dqid(i_enq_dqid), .i_enq_serialize(i_enq_serialize),
    .i_enq_except(i_enq_except), .i_enq_except_code(i_enq_except_code),
    .i_enq_robidx(i_enq_robidx), .i_rob_rdy(i_rob_rdy), .i_imm_rdy(i_imm_rdy),
    .i_rob_empty(i_rob_empty), .i_commit_serialize(i_commit_serialize),
    .i_dq_deq_cnt(i_dq_deq_cnt), .o_acc_cnt(o_acc_cnt), .o_stall(o_stall),
    .o_dq_enq_mask(o_dq_enq_mask), .o_ser_busy(o_ser_busy),
    .o_exceptwb_vld(o_exceptwb_vld), .o_exceptwb_robidx(o_exceptwb_robidx),
    .o_exceptwb_code(o_exceptwb_code), .o_stall_cnt(o_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [LCNT_W-1:0]       acc;
    logic                    stall;
    logic [NUM_DQ*WIDTH-1:0] mask;
    logic                    busy;
    logic                    ev;
    logic [ROBIDX_W-1:0]     erob;
    logic [4:0]              ecode;
    logic [127:0]            scnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: mode 0 normal, 1 waiting for ROB empty, 2 issuing the
  // serializing lane, 3 waiting for its commit.
  int          m_credit [NUM_DQ];
  int          m_mode;
  bit          m_ev;
  int          m_erob, m_ecode;
  int unsigned m_stalls [4];   // 0 rob, 1 imm, 2 credit, 3 serialize

  task automatic modelReset();
    for (int q = 0; q < NUM_DQ; q++) m_credit[q] = DQ_DEPTH;
    m_mode = 0; m_ev = 0; m_erob = 0; m_ecode = 0;
    for (int i = 0; i < 4; i++) m_stalls[i] = 0;
  endtask

  function automatic logic [WIDTH*DQID_W-1:0] dqids(input int a, input int b, input int c, input int d);
    return {DQID_W'(d), DQID_W'(c), DQID_W'(b), DQID_W'(a)};
  endfunction

  task automatic setCtl(input bit sq, input bit rob, input bit imm, input bit empty, input bit commit);
    i_squash_vld = sq; i_rob_rdy = rob; i_imm_rdy = imm;
    i_rob_empty = empty; i_commit_serialize = commit;
  endtask

  // Drive one cycle of lanes, record what the DUT must show this cycle, then
  // advance the model to the state after the next edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] vld, input logic [WIDTH*DQID_W-1:0] dq_p,
                               input logic [WIDTH-1:0] ser, input logic [WIDTH-1:0] exc,
                               input logic [NUM_DQ*CNT_W-1:0] deq);
    int   dq [WIDTH];
    int   cnt [NUM_DQ];
    int   nv, kc, j, lim, acc, nmode, reason;
    bit   ok, gate;
    exp_t e;
    i_enq_vld = vld; i_enq_dqid = dq_p; i_enq_serialize = ser; i_enq_except = exc;
    i_dq_deq_cnt = deq;
    i_enq_robidx = (WIDTH*ROBIDX_W)'($urandom);
    i_enq_except_code = (WIDTH*5)'($urandom);
    for (int l = 0; l < WIDTH; l++) dq[l] = int'(dq_p[l*DQID_W +: DQID_W]);
    nv = 0;
    for (int l = 0; l < WIDTH; l++) if (vld[l] && nv == l) nv = l + 1;
    kc = 0;
    for (int k = 1; k <= nv; k++) begin
      for (int q = 0; q < NUM_DQ; q++) cnt[q] = 0;
      for (int l = 0; l < k; l++) if (dq[l] < NUM_DQ) cnt[dq[l]]++;
      ok = 1;
      for (int q = 0; q < NUM_DQ; q++) if (cnt[q] > m_credit[q]) ok = 0;
      if (ok) kc = k;
    end
    j = -1;
    for (int l = 0; l < nv; l++) if (j < 0 && ser[l]) j = l;
    nmode = m_mode;
    lim = 0;
    case (m_mode)
      0: if (j == 0) nmode = 1; else lim = (j > 0 && j < kc) ? j : kc;
      1: if (i_rob_empty) nmode = 2;
      2: lim = (kc > 1) ? 1 : kc;
      default: if (i_commit_serialize) nmode = 0;
    endcase
    gate = i_squash_vld || !i_rob_rdy || !i_imm_rdy;
    acc = gate ? 0 : lim;
    if (m_mode == 2 && acc > 0) nmode = 3;
    if (i_squash_vld) nmode = 0;

    e.acc = LCNT_W'(acc);
    e.stall = vld[0] && acc == 0;
    e.mask = '0;
    for (int l = 0; l < acc; l++) if (dq[l] < NUM_DQ) e.mask[dq[l]*WIDTH + l] = 1'b1;
    e.busy = (m_mode != 0);
    e.ev = m_ev; e.erob = ROBIDX_W'(m_erob); e.ecode = 5'(m_ecode);
`ifdef DISPATCH_STALL_STATS_EN
    e.scnt = {m_stalls[0], m_stalls[1], m_stalls[2], m_stalls[3]};
`else
    e.scnt = '0;
`endif
    sb.push_back(e);

    if (e.stall) begin
      if (!i_rob_rdy) reason = 0;
      else if (!i_imm_rdy) reason = 1;
      else if (m_mode != 0 || j == 0) reason = 3;
      else reason = 2;
      m_stalls[reason]++;
    end
    m_ev = 0;
    for (int l = acc - 1; l >= 0; l--) begin
      if (exc[l]) begin
        m_ev = 1;
        m_erob = int'(i_enq_robidx[l*ROBIDX_W +: ROBIDX_W]);
        m_ecode = int'(i_enq_except_code[l*5 +: 5]);
      end
    end
    for (int q = 0; q < NUM_DQ; q++) begin
      if (i_squash_vld) m_credit[q] = DQ_DEPTH;
      else m_credit[q] = m_credit[q] + int'(deq[q*CNT_W +: CNT_W])
                         - $countones(e.mask[q*WIDTH +: WIDTH]);
    end
    if (i_squash_vld) m_ev = 0;
    m_mode = nmode;
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("acc_cnt", 128'(o_acc_cnt), 128'(e.acc));
    cmp("stall", 128'(o_stall), 128'(e.stall));
    cmp("enq_mask", 128'(o_dq_enq_mask), 128'(e.mask));
    cmp("ser_busy", 128'(o_ser_busy), 128'(e.busy));
    cmp("exceptwb_vld", 128'(o_exceptwb_vld), 128'(e.ev));
    if (e.ev) begin
      cmp("exceptwb_robidx", 128'(o_exceptwb_robidx), 128'(e.erob));
      cmp("exceptwb_code", 128'(o_exceptwb_code), 128'(e.ecode));
    end
    cmp("stall_cnt", o_stall_cnt, e.scnt);
  endtask

  always @(negedge clk) begin
    if (rst && sb.size() > 0) checkOutput(sb.pop_front());
  end

  function automatic logic [NUM_DQ*CNT_W-1:0] fullDeq();
    logic [NUM_DQ*CNT_W-1:0] d;
    for (int q = 0; q < NUM_DQ; q++) d[q*CNT_W +: CNT_W] = CNT_W'(DQ_DEPTH - m_credit[q]);
    return d;
  endfunction

  function automatic logic [NUM_DQ*CNT_W-1:0] randDeq();
    logic [NUM_DQ*CNT_W-1:0] d;
    int occ;
    for (int q = 0; q < NUM_DQ; q++) begin
      occ = DQ_DEPTH - m_credit[q];
      d[q*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, occ < 2 ? occ : 2));
    end
    return d;
  endfunction

  task automatic drainAll();
    applyStimulus('0, '0, '0, '0, fullDeq());
  endtask

  task automatic fillQueue(input int q, input int n);
    int k;
    while (n > 0) begin
      k = (n > WIDTH) ? WIDTH : n;
      applyStimulus(WIDTH'((1 << k) - 1), dqids(q, q, q, q), '0, '0, '0);
      n -= k;
    end
  endtask

  task automatic doReset();
    rst = 1'b0;
    i_enq_vld = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    modelReset();
  endtask

  initial begin
    logic [WIDTH*DQID_W-1:0] rd;
    logic [WIDTH-1:0]        rs, rx, rv;
    rst = 1'b0;
    setCtl(0, 1, 1, 0, 0);
    i_enq_vld = '0; i_enq_dqid = '0; i_enq_serialize = '0; i_enq_except = '0;
    i_enq_except_code = '0; i_enq_robidx = '0; i_dq_deq_cnt = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset state, then a full group across three queues.
    applyStimulus('0, '0, '0, '0, '0);
    applyStimulus(4'hF, dqids(0, 1, 0, 2), '0, '0, '0);

    // Queue 0 down to a single credit: prefix stops at its second lane.
    fillQueue(0, 13);
    applyStimulus(4'hF, dqids(1, 0, 0, 1), '0, '0, '0);
    applyStimulus(4'hF, dqids(0, 3, 1, 1), '0, '0, '0);
    drainAll();

    // Serialization sequence.
    applyStimulus(4'hF, dqids(0, 1, 2, 0), 4'b0100, '0, '0);
    applyStimulus(4'hF, dqids(0, 1, 2, 0), 4'b0001, '0, '0);
    applyStimulus(4'hF, dqids(0, 1, 2, 0), 4'b0001, '0, '0);
    setCtl(0, 1, 1, 1, 0);
    applyStimulus(4'hF, dqids(0, 1, 2, 0), 4'b0001, '0, '0);
    applyStimulus(4'hF, dqids(0, 1, 2, 0), 4'b0001, '0, '0);
    applyStimulus(4'hF, dqids(1, 1, 2, 0), '0, '0, '0);
    setCtl(0, 1, 1, 1, 1);
    applyStimulus(4'hF, dqids(1, 1, 2, 0), '0, '0, '0);
    setCtl(0, 1, 1, 0, 1);
    applyStimulus(4'hF, dqids(1, 1, 2, 0), '0, '0, '0);
    setCtl(0, 1, 1, 0, 0);
    drainAll();

    // Exceptions on lanes 1 and 3, fully accepted and then credit-capped.
    applyStimulus(4'hF, dqids(0, 1, 2, 3), '0, 4'b1010, '0);
    applyStimulus('0, '0, '0, '0, '0);
    drainAll();
    fillQueue(2, 16);
    applyStimulus(4'hF, dqids(1, 2, 2, 2), '0, 4'b1010, '0);
    applyStimulus('0, '0, '0, '0, '0);
    drainAll();

    // Squash while waiting for a serializing commit, then full credits again.
    fillQueue(1, 16);
    setCtl(0, 1, 1, 1, 0);
    applyStimulus(4'hF, dqids(0, 0, 0, 0), 4'b0001, '0, '0);
    applyStimulus(4'hF, dqids(0, 0, 0, 0), 4'b0001, '0, '0);
    applyStimulus(4'hF, dqids(0, 0, 0, 0), 4'b0001, 4'b0001, '0);
    setCtl(1, 1, 1, 1, 0);
    applyStimulus(4'hF, dqids(0, 0, 0, 0), '0, '0, '0);
    setCtl(0, 1, 1, 0, 0);
    fillQueue(1, 16);
    fillQueue(0, 16);
    drainAll();

    // Reset in the middle of a serialization.
    applyStimulus(4'hF, dqids(0, 1, 2, 0), 4'b0001, '0, '0);
    doReset();
    applyStimulus(4'hF, dqids(0, 1, 2, 0), '0, '0, '0);
    drainAll();

    // Stall attribution: rob not ready, then credit exhaustion.
    setCtl(0, 0, 1, 0, 0);
    repeat (5) applyStimulus(4'h1, dqids(0, 0, 0, 0), '0, '0, '0);
    setCtl(0, 1, 1, 0, 0);
    fillQueue(0, 16);
    repeat (3) applyStimulus(4'hF, dqids(0, 0, 0, 0), '0, '0, '0);
    drainAll();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rv = WIDTH'((1 << $urandom_range(0, WIDTH)) - 1);
      for (int l = 0; l < WIDTH; l++) begin
        rd[l*DQID_W +: DQID_W] = DQID_W'($urandom_range(0, NUM_DQ));
        rs[l] = ($urandom_range(0, 7) == 0);
        rx[l] = ($urandom_range(0, 5) == 0);
      end
      setCtl($urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0,
             $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) == 0);
      applyStimulus(rv, rd, rs, rx, randDeq());
    end

    setCtl(0, 1, 1, 0, 0);
    applyStimulus('0, '0, '0, '0, '0);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain actual %0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
